// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-address generator: FSM states,
// enable/disable constants and the redirect-target alignment mask.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } pc_state_t;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // Mask that clears the low log2(step) address bits; step must be a power of two.
   function automatic logic [63:0] align_mask(input int unsigned step);
      return ~(64'(step) - 64'd1);
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bus between the pipeline control logic (master) and the
// program-counter generator (slave).
interface pc_gen_if #(
   parameter int ADDR_W  = 32,
   parameter int STALL_W = 6
);
   logic [STALL_W-1:0] stall;
   logic               branch_en;
   logic [ADDR_W-1:0]  branch_addr;
   logic               exc_en;
   logic [ADDR_W-1:0]  exc_addr;
   logic               halt_req;
   logic [ADDR_W-1:0]  pc;
   logic               ins_en;
   logic               halted;
   logic               pend_valid;

   modport master (
      output stall, branch_en, branch_addr, exc_en, exc_addr, halt_req,
      input  pc, ins_en, halted, pend_valid
   );

   modport slave (
      input  stall, branch_en, branch_addr, exc_en, exc_addr, halt_req,
      output pc, ins_en, halted, pend_valid
   );
endinterface

// File: rtl/pc_redirect_buf.sv
// Holds a branch target that arrived while fetch was stalled so it can be
// taken once the stall drops. A new set overwrites the held target.
module pc_redirect_buf #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set,
   input  logic              clr,
   input  logic [ADDR_W-1:0] addr_in,
   output logic              pend_valid,
   output logic [ADDR_W-1:0] pend_addr
);

   // Clear wins over set; set captures (or overwrites) the deferred target.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_valid <= 1'b0;
         pend_addr  <= '0;
      end else if (clr) begin
         pend_valid <= 1'b0;
      end else if (set) begin
         pend_valid <= 1'b1;
         pend_addr  <= addr_in;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boots to RESET_VEC, steps sequentially, takes
// exception/branch redirects (deferring branches seen during a fetch stall)
// and parks in HALT until an exception restarts it.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int unsigned       STEP      = 4,
   parameter int                STALL_W   = 6
) (
   input logic    clk,
   input logic    rst,
   pc_gen_if.slave bus
);

   localparam logic [ADDR_W-1:0] ALIGN = ADDR_W'(align_mask(STEP));
   localparam logic [ADDR_W-1:0] INC   = ADDR_W'(STEP);

   pc_state_t         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              ins_en_q, ins_en_d;
   logic              halted_q, halted_d;

   logic              fetch_stall;
   logic              in_run;
   logic              pend_set;
   logic              pend_clr;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_addr;
   logic              unused_stall_bits;

   // Only the fetch-stage stall bit matters here; the rest of the vector is
   // consumed by other pipeline stages.
   assign fetch_stall       = bus.stall[0];
   assign unused_stall_bits = ^bus.stall;
   assign in_run            = (state_q == ST_RUN);

   // A branch during a stall is parked; anything that moves or halts the pc
   // (exception, unstalled edge, leaving RUN) drops the parked target.
   assign pend_set = in_run && !bus.exc_en && fetch_stall && bus.branch_en;
   assign pend_clr = !in_run || bus.exc_en || !fetch_stall;

   pc_redirect_buf #(
      .ADDR_W (ADDR_W)
   ) u_redirect_buf (
      .clk        (clk),
      .rst        (rst),
      .set        (pend_set),
      .clr        (pend_clr),
      .addr_in    (bus.branch_addr & ALIGN),
      .pend_valid (pend_valid),
      .pend_addr  (pend_addr)
   );

   // State and output registers; reset is synchronous and overrides all requests.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_VEC;
         ins_en_q <= DISABLE;
         halted_q <= DISABLE;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ins_en_q <= ins_en_d;
         halted_q <= halted_d;
      end
   end

   // Next-state and next-output decode; ins_en/halted are precomputed from the
   // next state so both registered outputs track the FSM exactly.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ins_en_d = ins_en_q;
      halted_d = halted_q;
      unique case (state_q)
         ST_BOOT: begin
            pc_d     = RESET_VEC;
            state_d  = ST_RUN;
            ins_en_d = ENABLE;
            halted_d = DISABLE;
         end
         ST_RUN: begin
            ins_en_d = ENABLE;
            halted_d = DISABLE;
            if (bus.exc_en) begin
               pc_d = bus.exc_addr & ALIGN;
            end else if (!fetch_stall) begin
               if (bus.branch_en) begin
                  pc_d = bus.branch_addr & ALIGN;
               end else if (pend_valid) begin
                  pc_d = pend_addr;
               end else begin
                  pc_d = pc_q + INC;
               end
               if (bus.halt_req) begin
                  state_d  = ST_HALT;
                  ins_en_d = DISABLE;
                  halted_d = ENABLE;
               end
            end
         end
         ST_HALT: begin
            ins_en_d = DISABLE;
            halted_d = ENABLE;
            if (bus.exc_en) begin
               pc_d     = bus.exc_addr & ALIGN;
               state_d  = ST_RUN;
               ins_en_d = ENABLE;
               halted_d = DISABLE;
            end
         end
         default: begin
            state_d  = ST_BOOT;
            pc_d     = RESET_VEC;
            ins_en_d = DISABLE;
            halted_d = DISABLE;
         end
      endcase
   end

   assign bus.pc         = pc_q;
   assign bus.ins_en     = ins_en_q;
   assign bus.halted     = halted_q;
   assign bus.pend_valid = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen with RESET_VEC=0x100, STEP=4.
module tb_pc_gen;

   localparam int ADDR_W  = 32;
   localparam int STALL_W = 6;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        ins_en;
      logic        halted;
      logic        pend_valid;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb[$];
   int   vectors;
   int   miscompares;

   pc_gen_if #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) bus ();

   pc_gen #(
      .ADDR_W    (ADDR_W),
      .RESET_VEC (32'h0000_0100),
      .STEP      (4),
      .STALL_W   (STALL_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pops the oldest expectation and compares it with the registered outputs.
   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL scoreboard: observed empty queue, expected an entry");
      end else begin
         e = sb.pop_front();
         vectors++;
         assert ({bus.pc, bus.ins_en, bus.halted, bus.pend_valid} ===
                 {e.pc, e.ins_en, e.halted, e.pend_valid})
         else begin
            miscompares++;
            $error("[TB] FAIL %s: observed pc=%h ins_en=%b halted=%b pend=%b, expected pc=%h ins_en=%b halted=%b pend=%b",
                   e.tag, bus.pc, bus.ins_en, bus.halted, bus.pend_valid,
                   e.pc, e.ins_en, e.halted, e.pend_valid);
         end
      end
   endtask

   // Drives one cycle of inputs, records the expected post-edge outputs,
   // then clocks once and checks. Upper stall bits get noise since only bit 0 matters.
   task automatic applyStimulus(input string tag, input logic r, input logic s,
                                input logic be, input logic [31:0] ba,
                                input logic ee, input logic [31:0] ea,
                                input logic hr, input logic [31:0] epc,
                                input logic eins, input logic ehalt, input logic epend);
      exp_t e;
      rst             = r;
      bus.stall       = {5'($urandom), s};
      bus.branch_en   = be;
      bus.branch_addr = ba;
      bus.exc_en      = ee;
      bus.exc_addr    = ea;
      bus.halt_req    = hr;
      e.tag = tag; e.pc = epc; e.ins_en = eins; e.halted = ehalt; e.pend_valid = epend;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // Linear sequence of directed steps.
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b0;
      bus.stall = '0; bus.branch_en = 1'b0; bus.branch_addr = '0;
      bus.exc_en = 1'b0; bus.exc_addr = '0; bus.halt_req = 1'b0;

      // Reset, then boot: one cycle with ins_en low, then 0x100, 0x104, 0x108.
      applyStimulus("reset0",    0,0,0,32'h0,0,32'h0,0, 32'h100,0,0,0);
      applyStimulus("reset1",    0,0,0,32'h0,0,32'h0,0, 32'h100,0,0,0);
      applyStimulus("boot",      1,0,0,32'h0,0,32'h0,0, 32'h100,1,0,0);
      applyStimulus("seq104",    1,0,0,32'h0,0,32'h0,0, 32'h104,1,0,0);
      applyStimulus("seq108",    1,0,0,32'h0,0,32'h0,0, 32'h108,1,0,0);

      // Stall with two branches; the later target wins once the stall drops.
      applyStimulus("br200",     1,0,1,32'h200,0,32'h0,0, 32'h200,1,0,0);
      applyStimulus("stl_br400", 1,1,1,32'h400,0,32'h0,0, 32'h200,1,0,1);
      applyStimulus("stl_br500", 1,1,1,32'h500,0,32'h0,0, 32'h200,1,0,1);
      applyStimulus("stl_hold",  1,1,0,32'h0,0,32'h0,0, 32'h200,1,0,1);
      applyStimulus("pend500",   1,0,0,32'h0,0,32'h0,0, 32'h500,1,0,0);
      applyStimulus("seq504",    1,0,0,32'h0,0,32'h0,0, 32'h504,1,0,0);

      // Exception during stall with a pending branch.
      applyStimulus("stl_pend",  1,1,1,32'h400,0,32'h0,0, 32'h504,1,0,1);
      applyStimulus("exc_stall", 1,1,0,32'h0,1,32'h80,0, 32'h80,1,0,0);
      applyStimulus("seq84",     1,0,0,32'h0,0,32'h0,0, 32'h84,1,0,0);

      // Live branch supersedes a pending one.
      applyStimulus("stl_br600", 1,1,1,32'h600,0,32'h0,0, 32'h84,1,0,1);
      applyStimulus("live700",   1,0,1,32'h700,0,32'h0,0, 32'h700,1,0,0);
      applyStimulus("seq704",    1,0,0,32'h0,0,32'h0,0, 32'h704,1,0,0);

      // Halt request while stalled is ignored.
      applyStimulus("halt_stl",  1,1,0,32'h0,0,32'h0,1, 32'h704,1,0,0);

      // Halt with concurrent branch, frozen for 10 cycles, exception restarts.
      applyStimulus("halt_br",   1,0,1,32'h300,0,32'h0,1, 32'h300,0,1,0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus("halt_frz", 1,1'(i),1,32'h900,0,32'h0,1'(i >> 1), 32'h300,0,1,0);
      end
      applyStimulus("halt_exc",  1,0,0,32'h0,1,32'h80,0, 32'h80,1,0,0);

      // Wrap at the top of the address space and target alignment.
      applyStimulus("br_top",    1,0,1,32'hFFFF_FFFC,0,32'h0,0, 32'hFFFF_FFFC,1,0,0);
      applyStimulus("wrap",      1,0,0,32'h0,0,32'h0,0, 32'h0,1,0,0);
      applyStimulus("br_align",  1,0,1,32'h1003,0,32'h0,0, 32'h1000,1,0,0);
      applyStimulus("exc_align", 1,0,0,32'h0,1,32'h82,0, 32'h80,1,0,0);
      applyStimulus("stl_mis",   1,1,1,32'h2002,0,32'h0,0, 32'h80,1,0,1);
      applyStimulus("pend_alg",  1,0,0,32'h0,0,32'h0,0, 32'h2000,1,0,0);

      // Reset during pending overrides simultaneous requests.
      applyStimulus("stl_p2",    1,1,1,32'h400,0,32'h0,0, 32'h2000,1,0,1);
      applyStimulus("rst_pend",  0,1,1,32'h440,1,32'h80,1, 32'h100,0,0,0);
      applyStimulus("boot2",     1,0,0,32'h0,0,32'h0,0, 32'h100,1,0,0);
      applyStimulus("seq104b",   1,0,0,32'h0,0,32'h0,0, 32'h104,1,0,0);

      // Reset during HALT.
      applyStimulus("halt2",     1,0,0,32'h0,0,32'h0,1, 32'h108,0,1,0);
      applyStimulus("rst_halt",  0,0,0,32'h0,1,32'h80,0, 32'h100,0,0,0);
      applyStimulus("boot3",     1,0,0,32'h0,0,32'h0,0, 32'h100,1,0,0);
      applyStimulus("seq104c",   1,0,0,32'h0,0,32'h0,0, 32'h104,1,0,0);

      if (sb.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
